// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data RAM arbiter.
// Contention policy is chosen in mem_arb_grant by the MEM_ARB_RR_EN macro.
package mem_bus_arbiter_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam int   CNT_W      = 8;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select for the RAM arbiter.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: MEM has fixed priority.
module mem_arb_grant
  import mem_bus_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  logic   if_ack,
  input  logic   mem_ack,
  input  grant_e last_grant,
  output logic   grant_vld,
  output grant_e grant
);

  // A port being acked this cycle still holds its request; it must not be re-granted.
  logic if_live;
  logic mem_live;

  assign if_live   = if_req & ~if_ack;
  assign mem_live  = mem_req & ~mem_ack;
  assign grant_vld = if_live | mem_live;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = GRANT_IF;
    if (if_live && mem_live) begin
      if (last_grant == GRANT_IF) grant = GRANT_MEM;
      else                        grant = GRANT_IF;
    end else if (mem_live) begin
      grant = GRANT_MEM;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == GRANT_MEM);

  always_comb begin
    grant = GRANT_IF;
    if (mem_live) grant = GRANT_MEM;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and MEM-stage ports,
// with registered acks, timeout abort and stall requests. MEM_ARB_RR_EN selects round-robin.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [DW/8-1:0] mem_sel,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_rdata,
  output logic            mem_ack,
  output logic            stallreq_if,
  output logic            stallreq_mem,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [DW/8-1:0] ram_sel,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata,
  input  logic            ram_ready,
  output logic            bus_err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state;
  grant_e           last_grant;
  grant_e           grant;
  logic             grant_vld;
  logic [CNT_W-1:0] to_cnt;

  mem_arb_grant u_grant (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .if_ack     (if_ack),
    .mem_ack    (mem_ack),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_IF;
      to_cnt     <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_sel    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            last_grant <= grant;
            to_cnt     <= '0;
            ram_ce     <= 1'b1;
            if (grant == GRANT_MEM) begin
              ram_we    <= mem_we;
              ram_sel   <= mem_sel;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              state     <= ARB_BUSY_MEM;
            end else begin
              ram_we    <= 1'b0;
              ram_sel   <= '1;
              ram_addr  <= if_addr;
              ram_wdata <= '0;
              state     <= ARB_BUSY_IF;
            end
          end
        end
        ARB_BUSY_IF, ARB_BUSY_MEM: begin
          // ram_ready on the final counted cycle still completes normally.
          if (ram_ready || (to_cnt == TO_LAST)) begin
            ram_ce  <= 1'b0;
            state   <= ARB_IDLE;
            bus_err <= ~ram_ready;
            if (state == ARB_BUSY_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= ram_ready ? ram_rdata : '0;
            end else begin
              mem_ack   <= 1'b1;
              mem_rdata <= (ram_ready && !ram_we) ? ram_rdata : '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences and
// randomized episodes scored against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, ram_ready = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic        if_ack, mem_ack, stallreq_if, stallreq_mem, ram_ce, ram_we, bus_err;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata, ram_data;
    int          delay;      // ram_ce cycles before ram_ready; >= TO never answers
  } acc_t;

  typedef struct {
    acc_t        a;
    int          ack_cyc;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    acc_t        a;
    logic [31:0] x_rdata;
    bit          x_err;
    int          x_lat;
  } vec_t;

  acc_t q_if[$], q_mem[$];
  exp_t xq[$];
  vec_t vt[7];
  int   n_tests = 0, n_fail = 0;
  bit   m_last = 1'b0;           // model's last grant: 0 = IF, 1 = MEM
  bit   scramble = 1'b0;
  int   last_cyc;
  bit   last_port, last_err;
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic acc_t mk(input bit is_mem, input bit we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input int delay);
    acc_t a;
    a.is_mem = is_mem; a.we = is_mem ? we : 1'b0; a.sel = is_mem ? sel : 4'hf;
    a.addr = addr; a.wdata = wdata; a.ram_data = rd; a.delay = delay;
    return a;
  endfunction

  // Transaction-level schedule: each grant occupies the RAM until its ack cycle; the
  // arbiter is free to grant the other port in that ack cycle, the acked port one cycle later.
  task automatic build_expected();
    int t_idle = 0, r_if = 0, r_mem = 0, i_if = 0, i_mem = 0, g, k;
    bit a_if, a_mem, pick;
    exp_t e;
    xq.delete();
    while (i_if < q_if.size() || i_mem < q_mem.size()) begin
      g = t_idle;
      a_if  = (i_if < q_if.size()) && (r_if <= g);
      a_mem = (i_mem < q_mem.size()) && (r_mem <= g);
      if (!a_if && !a_mem) begin
        g = 1 << 30;
        if (i_if < q_if.size() && r_if < g) g = r_if;
        if (i_mem < q_mem.size() && r_mem < g) g = r_mem;
        a_if  = (i_if < q_if.size()) && (r_if <= g);
        a_mem = (i_mem < q_mem.size()) && (r_mem <= g);
      end
      if (a_if && a_mem) begin
`ifdef MEM_ARB_RR_EN
        pick = ~m_last;
`else
        pick = 1'b1;
`endif
      end else begin
        pick = a_mem;
      end
      e.a       = pick ? q_mem[i_mem] : q_if[i_if];
      k         = (e.a.delay < TO) ? e.a.delay : TO - 1;
      e.err     = (e.a.delay >= TO);
      e.ack_cyc = g + 2 + k;
      e.rdata   = (e.err || (e.a.is_mem && e.a.we)) ? 32'h0 : e.a.ram_data;
      xq.push_back(e);
      t_idle = e.ack_cyc;
      m_last = pick;
      if (pick) begin r_mem = e.ack_cyc + 1; i_mem++; end
      else      begin r_if  = e.ack_cyc + 1; i_if++;  end
    end
  endtask

  // Drives both requesters and a RAM model cycle by cycle, comparing acks and RAM strobes.
  task automatic run_episode();
    int  i_if = 0, i_mem = 0, acks = 0, ai = -1, ce_cnt = 0, budget;
    bit  prev_ce = 1'b0, pa_if = 1'b0, pa_mem = 1'b0;
    exp_t e;
    build_expected();
    if (xq.size() == 0) return;
    budget = xq[xq.size()-1].ack_cyc + 3;
    for (int c = 0; c <= budget; c++) begin
      @(posedge clk); #1;
      chk("ack_exclusive", {31'd0, if_ack & mem_ack}, 32'd0);
      if (if_ack || mem_ack) begin
        if (acks < xq.size()) begin
          e = xq[acks];
          chk("ack_port", {31'd0, mem_ack}, {31'd0, e.a.is_mem});
          chk("ack_cycle", c, e.ack_cyc);
          chk("ack_rdata", mem_ack ? mem_rdata : if_rdata, e.rdata);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
          last_cyc = c; last_port = mem_ack; last_err = bus_err;
          last_rdata = mem_ack ? mem_rdata : if_rdata;
        end else begin
          chk("spurious_ack", acks, xq.size() - 1);
        end
        acks++;
      end else begin
        chk("stray_bus_err", {31'd0, bus_err}, 32'd0);
      end
      if (pa_if)  i_if++;
      if (pa_mem) i_mem++;
      pa_if = if_ack; pa_mem = mem_ack;
      if_req  = (i_if < q_if.size());
      if_addr = if_req ? q_if[i_if].addr : 32'h0;
      mem_req = (i_mem < q_mem.size());
      if (mem_req) begin
        mem_we = q_mem[i_mem].we; mem_sel = q_mem[i_mem].sel;
        mem_addr = q_mem[i_mem].addr; mem_wdata = q_mem[i_mem].wdata;
      end else begin
        mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
      end
      ram_ready = 1'b0;
      ram_rdata = $urandom;
      if (ram_ce) begin
        if (!prev_ce) begin ai++; ce_cnt = 0; end
        if (ai < xq.size()) begin
          e = xq[ai];
          chk("ram_addr", ram_addr, e.a.addr);
          chk("ram_we", {31'd0, ram_we}, {31'd0, e.a.we});
          chk("ram_sel", {28'd0, ram_sel}, {28'd0, e.a.sel});
          if (e.a.is_mem) chk("ram_wdata", ram_wdata, e.a.wdata);
          if (ce_cnt == e.a.delay) begin ram_ready = 1'b1; ram_rdata = e.a.ram_data; end
          if (scramble && e.a.is_mem) begin
            mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom); mem_we = 1'($urandom);
          end else if (scramble) begin
            if_addr = $urandom;
          end
        end else begin
          chk("extra_access", ai, xq.size() - 1);
        end
        ce_cnt++;
      end
      prev_ce = ram_ce;
      #1;
      chk("stallreq_if", {31'd0, stallreq_if}, {31'd0, if_req & ~pa_if});
      chk("stallreq_mem", {31'd0, stallreq_mem}, {31'd0, mem_req & ~pa_mem});
    end
    chk("ack_count", acks, xq.size());
    ram_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{mk(0, 0, 4'hf, 32'h0000_0004, 0, 32'h3401_1100, 0), 32'h3401_1100, 0, 2};
    vt[1] = '{mk(1, 1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 0), 32'h0, 0, 2};
    vt[2] = '{mk(1, 0, 4'hf, 32'h0000_0200, 0, 32'hCAFE_F00D, 3), 32'hCAFE_F00D, 0, 5};
    vt[3] = '{mk(0, 0, 4'hf, 32'h0000_0008, 0, 32'h0BAD_F00D, TO - 1), 32'h0BAD_F00D, 0, TO + 1};
    vt[4] = '{mk(0, 0, 4'hf, 32'h0000_000C, 0, 32'h5555_AAAA, TO), 32'h0, 1, TO + 1};
    vt[5] = '{mk(1, 0, 4'b1000, 32'h0000_0300, 0, 32'h7777_1111, 40), 32'h0, 1, TO + 1};
    vt[6] = '{mk(1, 1, 4'hf, 32'h0000_0400, 32'h0102_0304, 32'h9999_9999, 7), 32'h0, 0, 9};

    #12;
    chk("rst_outputs", {if_ack, mem_ack, ram_ce, ram_we, bus_err, stallreq_if, stallreq_mem, ram_sel},
        32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    #7 rst = 1'b0;

    foreach (vt[i]) begin
      q_if.delete(); q_mem.delete();
      if (vt[i].a.is_mem) q_mem.push_back(vt[i].a);
      else                q_if.push_back(vt[i].a);
      run_episode();
      chk($sformatf("vec%0d_port", i), {31'd0, last_port}, {31'd0, vt[i].a.is_mem});
      chk($sformatf("vec%0d_lat", i), last_cyc, vt[i].x_lat);
      chk($sformatf("vec%0d_rdata", i), last_rdata, vt[i].x_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, last_err}, {31'd0, vt[i].x_err});
    end

    // Contention: both ports request together and keep requesting for two accesses each.
    q_if.delete(); q_mem.delete();
    for (int i = 0; i < 2; i++) begin
      q_if.push_back(mk(0, 0, 4'hf, 32'h1000 + 4 * i, 0, 32'hA000_0000 + i, 0));
      q_mem.push_back(mk(1, 0, 4'hf, 32'h2000 + 4 * i, 0, 32'hB000_0000 + i, 0));
    end
    run_episode();

    // ram_ready while idle must not produce any ack.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ram_ready = 1'b1; ram_rdata = 32'hFFFF_0000;
      chk("idle_ready", {28'd0, if_ack, mem_ack, ram_ce, bus_err}, 32'h0);
    end
    ram_ready = 1'b0;

    // MEM inputs change while the access is in flight; the RAM side must hold.
    scramble = 1'b1;
    q_if.delete(); q_mem.delete();
    q_mem.push_back(mk(1, 1, 4'b0110, 32'h0000_0500, 32'h1357_9BDF, 0, 4));
    run_episode();
    scramble = 1'b0;

    // Reset in the second BUSY cycle: outputs drop at once, no ack follows.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(posedge clk); #1;
    chk("busy1_ce", {31'd0, ram_ce}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {28'd0, ram_ce, if_ack, mem_ack, bus_err}, 32'h0);
    if_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    m_last = 1'b0;
    q_if.delete(); q_mem.delete();
    q_if.push_back(mk(0, 0, 4'hf, 32'h0000_0044, 0, 32'h2468_ACE0, 1));
    run_episode();

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      int n_if, n_mem;
      q_if.delete(); q_mem.delete();
      n_if = $urandom_range(0, 3);
      n_mem = $urandom_range(0, 3);
      if (n_if == 0 && n_mem == 0) n_if = 1;
      scramble = 1'($urandom);
      for (int i = 0; i < n_if + n_mem; i++) begin
        int d;
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
        if (i < n_if)
          q_if.push_back(mk(0, 0, 4'hf, $urandom & 32'hFFFF_FFFC, 0, $urandom, d));
        else
          q_mem.push_back(mk(1, 1'($urandom), 4'($urandom_range(1, 15)),
                             $urandom & 32'hFFFF_FFFC, $urandom, $urandom, d));
      end
      run_episode();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
